// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF->ID pipeline stage.
//   INST_ADDR_BUS_W / INST_BUS_W : default pc and instruction widths
//   RST_ENABLE                   : active level of the synchronous reset
//   skid_state_t                 : occupancy encoding of the 2-entry skid buffer
package if_id_stage_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/if_id_stage_pipe_skid_buf.sv
// pipe_skid_buf: generic WIDTH-bit valid/ready register slice.
// Build option: IF_ID_SKID_EN
//   undefined -> single entry, in_ready = ~out_valid | out_ready (combinational from out_ready)
//   defined   -> two entries (main + skid), in_ready decoded from registered state only
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             drop every held beat and any beat offered this cycle
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
// The main register is written with zeros whenever it empties, so out_data is
// all-zero whenever out_valid is low.
module pipe_skid_buf
  import if_id_stage_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic accept;
  logic consume;

`ifdef IF_ID_SKID_EN

  skid_state_t      state_reg, state_next;
  logic [WIDTH-1:0] main_data_reg, main_data_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;

  // Only the skid entry blocks upstream, so in_ready never sees out_ready.
  assign in_ready  = (state_reg != SKID_TWO);
  assign out_valid = (state_reg != SKID_EMPTY);
  assign out_data  = main_data_reg;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg     <= SKID_EMPTY;
      main_data_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    skid_data_next = skid_data_reg;
    case (state_reg)
      SKID_EMPTY: begin
        if (accept) begin
          state_next     = SKID_ONE;
          main_data_next = in_data;
        end
      end
      SKID_ONE: begin
        if (accept && !consume) begin
          state_next     = SKID_TWO;
          skid_data_next = in_data;
        end else if (accept && consume) begin
          main_data_next = in_data;
        end else if (consume) begin
          state_next     = SKID_EMPTY;
          main_data_next = '0;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only a consume can move the state.
        if (consume) begin
          state_next     = SKID_ONE;
          main_data_next = skid_data_reg;
          skid_data_next = '0;
        end
      end
      default: begin
        state_next     = SKID_EMPTY;
        main_data_next = '0;
        skid_data_next = '0;
      end
    endcase
    if (clear) begin
      state_next     = SKID_EMPTY;
      main_data_next = '0;
      skid_data_next = '0;
    end
  end

`else

  logic             main_valid_reg, main_valid_next;
  logic [WIDTH-1:0] main_data_reg, main_data_next;

  assign in_ready  = ~main_valid_reg | out_ready;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign accept    = in_valid & in_ready;
  assign consume   = main_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
    end
  end

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    if (clear) begin
      main_valid_next = 1'b0;
      main_data_next  = '0;
    end else if (accept) begin
      // Also covers consume+accept: the new beat replaces the old one, no bubble.
      main_valid_next = 1'b1;
      main_data_next  = in_data;
    end else if (consume) begin
      main_valid_next = 1'b0;
      main_data_next  = '0;
    end
  end

`endif

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF->ID pipeline register carrying {pc, inst} as one beat.
// Build option: IF_ID_SKID_EN selects the 2-entry skid buffer (see pipe_skid_buf).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       kill held beats and discard this cycle's incoming beat
//   in_valid/in_ready           fetch-side handshake, payload in_pc/in_inst
//   out_valid/out_ready         decode-side handshake, payload out_pc/out_inst
//   stall_cnt                   saturating count of out_valid & ~out_ready cycles
// out_pc/out_inst are zero (NOP) whenever out_valid is low.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ADDR_W+INST_W-1:0] beat_out;
  logic [CNT_W-1:0]         stall_cnt_reg, stall_cnt_next;

  pipe_skid_buf #(
    .WIDTH(ADDR_W + INST_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_pc, in_inst}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (beat_out)
  );

  assign out_pc    = beat_out[ADDR_W+INST_W-1:INST_W];
  assign out_inst  = beat_out[INST_W-1:0];
  assign stall_cnt = stall_cnt_reg;

  // Flush deliberately does not touch the counter; only reset clears it.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (out_valid && !out_ready && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage (both IF_ID_SKID_EN builds).
// The stimulus task pushes each accepted beat into a queue and empties it on
// flush/reset; an independent monitor on the falling edge pops and compares
// every consumed beat, and checks bubbles, hold stability and stall_cnt.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  stall_cnt;

`ifdef IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  if_id_stage #(
    .ADDR_W(32),
    .INST_W(32),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl, output logic acc);
    logic exp_rdy;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #3;
    exp_rdy = SKID ? (q.size() < 2) : ((q.size() == 0) || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    #3;
    acc = v & in_ready & ~fl;
    if (fl) q.delete();
    else if (v && in_ready) q.push_back({pc, inst});
    $display("cyc t=%0t v=%0b pc=%h rdy=%0b flush=%0b acc=%0b", $time, v, pc, ordy, fl, acc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    q.delete();
    rst = 1'b0;
  endtask

  // Monitor
  logic        hold_chk = 1'b0;
  logic [31:0] hold_pc, hold_inst;
  int          m_cnt = 0;
  logic        occ;
  logic [63:0] exp_beat;

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        m_cnt    = 0;
        hold_chk = 1'b0;
      end else begin
        occ = (q.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(occ));
        if (!out_valid) begin
          chk("bubble_pc", out_pc, 32'h0);
          chk("bubble_inst", out_inst, 32'h0);
        end
        if (hold_chk) begin
          chk("hold_pc", out_pc, hold_pc);
          chk("hold_inst", out_inst, hold_inst);
        end
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (out_valid && out_ready && occ) begin
          exp_beat = q.pop_front();
          n_pop++;
          chk("beat_pc", out_pc, exp_beat[63:32]);
          chk("beat_inst", out_inst, exp_beat[31:0]);
        end
        if (occ && !out_ready && m_cnt < 15) m_cnt++;
        hold_chk  = occ && !out_ready && !flush;
        hold_pc   = out_pc;
        hold_inst = out_inst;
      end
    end
  end

  // Stimulus
  logic        acc, got, rv, rr, rf;
  logic [31:0] rpc;

  initial begin
    do_reset();

    // 1) reset state
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);

    // 2) back-to-back stream
    cycle(1'b1, 32'h100, 32'h0000_0013, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h104, 32'h0010_0093, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h108, 32'h0020_0113, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("stream_count", 32'(n_pop), 32'd3);

    // 3) backpressure for 5 cycles while a second beat is offered
    cycle(1'b1, 32'h200, 32'h00a0_0093, 1'b0, 1'b0, acc);
    got = 1'b0;
    repeat (5) begin
      cycle(!got, 32'h204, 32'h00b0_0113, 1'b0, 1'b0, acc);
      if (acc) got = 1'b1;
    end
    chk("stall5", 32'(stall_cnt), 32'd5);
    chk("held_pc", out_pc, 32'h200);
    chk("held_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 10 && (!got || q.size() != 0); i++) begin
      cycle(!got, 32'h204, 32'h00b0_0113, 1'b1, 1'b0, acc);
      if (acc) got = 1'b1;
    end
    chk("release_count", 32'(n_pop), 32'd5);

    // 4) flush against a same-cycle accept, then against a held beat
    cycle(1'b1, 32'h300, 32'h0030_0193, 1'b1, 1'b1, acc);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_inst", out_inst, 32'h0);
    cycle(1'b1, 32'h310, 32'h0031_0193, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h314, 32'h0032_0193, 1'b0, 1'b1, acc);
    chk("flush_held_valid", 32'(out_valid), 32'h0);
    chk("flush_held_pc", out_pc, 32'h0);

    // 5) saturation, and flush leaves the counter alone
    cycle(1'b1, 32'h400, 32'h0040_0213, 1'b0, 1'b0, acc);
    repeat (20) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("stall_sat_flush", 32'(stall_cnt), 32'd15);

    // reset in the middle of a transfer
    cycle(1'b1, 32'h500, 32'h0050_0293, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h504, 32'h0051_0293, 1'b0, 1'b0, acc);
    do_reset();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_pc", out_pc, 32'h0);
    chk("midrst_stall", 32'(stall_cnt), 32'h0);

    // 6) random valid/ready/flush mix
    rpc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      rf = ($urandom_range(0, 31) == 0);
      cycle(rv, rpc, rpc * 32'd3 + 32'd1, rr, rf, acc);
      if (acc) rpc = rpc + 32'd4;
    end
    repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    chk("final_empty", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
